// File: rtl/ram_stream_pkg.sv
// Shared types for the RAM stream reader: the burst sequencing states.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry FIFO of {last, data} that absorbs the RAM read latency.
// A push and a pop in the same cycle are both honoured; count and head are registered.
module stream_buf2 #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_push_last,
    input  logic                  i_pop,
    output logic [1:0]            o_count,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_head_last
);

    logic [DATA_WIDTH:0] r_entry [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    // NOTE: storage is not reset; r_count alone decides which entries hold live data.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_entry[r_wr_ptr] <= {i_push_last, i_push_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_head_data = r_entry[r_rd_ptr][DATA_WIDTH-1:0];
    assign o_head_last = r_entry[r_rd_ptr][DATA_WIDTH];

    // The reader's credit rule must never let these happen.
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(i_pop && (r_count == 2'd0)));

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(i_push && (r_count == 2'd2)));

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side master for a simple dual-port RAM: streams a burst of words on valid/ready.
// The one-cycle RAM latency is hidden by a 2-entry buffer and a credit-based issue rule.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rddata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [1:0]            w_count;
    logic                  w_head_last;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_last_issue;
    logic [2:0]            w_used;

    assign w_pop        = out_valid & out_ready;
    // Buffer slots still committed after this cycle's pop: stored words plus the read in flight.
    assign w_used       = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_last_issue = (r_remaining == '0);

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) w_state_nxt = RUN;
            end
            RUN: begin
                w_issue = (w_used < 3'd2);
                if (w_issue && w_last_issue) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if ((w_count == 2'd0) && !r_inflight) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_cur_addr      <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue) r_inflight_last <= w_last_issue;
            if ((r_state == IDLE) && cmd_valid) begin
                r_cur_addr  <= cmd_addr;
                r_remaining <= cmd_len;
            end else if (w_issue) begin
                r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - ADDR_WIDTH'(1);
            end
        end
    end

    // Data arriving this cycle belongs to the read issued last cycle.
    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (ram_rddata),
        .i_push_last (r_inflight_last),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head_data (out_data),
        .o_head_last (w_head_last)
    );

    assign ram_addr  = r_cur_addr;
    assign out_valid = (w_count != 2'd0);
    assign out_last  = out_valid & w_head_last;
    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAMs, a wide and a narrow DUT, scenario tasks
// comparing each streamed burst against words computed directly from RAM contents.
module tb_ram_stream_reader;

    localparam int AW  = 16;
    localparam int DW  = 64;
    localparam int SAW = 4;
    localparam int SDW = 8;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          use_small = 1'b0;
    logic          fill_en = 1'b0;
    logic          fill_rand = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;

    // Wide DUT and its RAM.
    logic          b_cmd_valid, b_cmd_ready, b_out_valid, b_out_last, b_busy;
    logic [AW-1:0] b_ram_addr;
    logic [DW-1:0] b_ram_rddata, b_out_data;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Narrow DUT (4-bit addresses) and its RAM.
    logic           s_cmd_valid, s_cmd_ready, s_out_valid, s_out_last, s_busy;
    logic [SAW-1:0] s_ram_addr;
    logic [SDW-1:0] s_ram_rddata, s_out_data;
    logic [SDW-1:0] s_mem [0:(1<<SAW)-1];

    logic          m_cmd_ready, m_out_valid, m_out_last, m_busy;
    logic [DW-1:0] m_out_data;

    assign b_cmd_valid = cmd_valid & ~use_small;
    assign s_cmd_valid = cmd_valid & use_small;
    assign m_cmd_ready = use_small ? s_cmd_ready : b_cmd_ready;
    assign m_out_valid = use_small ? s_out_valid : b_out_valid;
    assign m_out_last  = use_small ? s_out_last  : b_out_last;
    assign m_busy      = use_small ? s_busy      : b_busy;
    assign m_out_data  = use_small ? DW'(s_out_data) : b_out_data;

    ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ram_addr(b_ram_addr), .ram_rddata(b_ram_rddata),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy)
    );

    ram_stream_reader #(.ADDR_WIDTH(SAW), .DATA_WIDTH(SDW)) u_small (
        .clk(clk), .rst(rst),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_addr(cmd_addr[SAW-1:0]), .cmd_len(cmd_len[SAW-1:0]),
        .ram_addr(s_ram_addr), .ram_rddata(s_ram_rddata),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_last(s_out_last), .busy(s_busy)
    );

    // Registered-address read; on a same-edge conflict the read returns the new value.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < (1 << AW); i++)
                mem[i] <= fill_rand ? {$urandom(), $urandom()} : DW'(i);
        end else if (we) begin
            mem[waddr] <= wdata;
        end
        b_ram_rddata <= (we && !fill_en && (waddr == b_ram_addr)) ? wdata : mem[b_ram_addr];
    end

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < (1 << SAW); i++)
                s_mem[i] <= fill_rand ? SDW'($urandom()) : SDW'(i);
        end
        s_ram_rddata <= s_mem[s_ram_addr];
    end

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    wr_t           wr_sched [$];
    int            first_valid, last_beat_cyc, valid_cycles, stable_err, idle_cyc;

    // Reference: word i of a burst is the RAM word at (start + i) modulo the RAM size.
    function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] start, input int i);
        if (use_small) return DW'(s_mem[(int'(start) + i) % (1 << SAW)]);
        return mem[(int'(start) + i) % (1 << AW)];
    endfunction

    task automatic fill(input logic rnd);
        fill_rand = rnd;
        fill_en   = 1'b1;
        @(negedge clk);
        fill_en   = 1'b0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic apply_writes(input int cyc);
        we = 1'b0;
        foreach (wr_sched[k]) begin
            if (wr_sched[k].cyc == cyc) begin
                we = 1'b1; waddr = wr_sched[k].addr; wdata = wr_sched[k].data;
            end
        end
    endtask

    // Issues one command (cycle 0) and collects accepted beats; cycles counted from acceptance.
    // mode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
    task automatic run_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                             input int mode, input int max_beats, input bit wait_idle);
        int cyc, limit, want;
        bit stalled, rdy;
        logic [DW-1:0] held_d;
        logic held_l;
        got_data.delete(); got_last.delete();
        first_valid = -1; last_beat_cyc = -1; valid_cycles = 0; stable_err = 0; idle_cyc = -1;
        want  = (int'(len) + 1 < max_beats) ? int'(len) + 1 : max_beats;
        limit = 40 + 4 * want;
        held_d = '0; held_l = 1'b0;
        checks++;
        if (m_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_before_cmd got=%b want=1", m_cmd_ready);
        end
        cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1; stalled = 1'b0;
        while (got_data.size() < want && cyc < limit) begin
            apply_writes(cyc);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (m_out_valid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
                if (stalled && (m_out_data !== held_d || m_out_last !== held_l)) stable_err++;
                if (rdy) begin
                    got_data.push_back(m_out_data);
                    got_last.push_back(m_out_last);
                    last_beat_cyc = cyc;
                end
                stalled = !rdy; held_d = m_out_data; held_l = m_out_last;
            end else begin
                if (stalled) stable_err++;
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        we = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got_data.size() != want) begin
            failures++;
            $display("FAIL burst_timeout beats=%0d want=%0d", got_data.size(), want);
        end
        if (wait_idle) begin
            out_ready = 1'b1;
            while (m_cmd_ready !== 1'b1 && cyc < limit + 20) begin
                if (m_out_valid) valid_cycles++;
                @(negedge clk);
                cyc++;
            end
            out_ready = 1'b0;
            idle_cyc = cyc;
            checks++;
            if (m_cmd_ready !== 1'b1 || m_busy !== 1'b0) begin
                failures++;
                $display("FAIL return_to_idle cmd_ready=%b busy=%b want 1/0", m_cmd_ready, m_busy);
            end
        end
    endtask

    task automatic test_reset;
        checks += 5;
        if (b_cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b want=1", b_cmd_ready); end
        if (b_busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b want=0", b_busy); end
        if (b_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", b_out_valid); end
        if (b_out_last !== 1'b0)  begin failures++; $display("FAIL reset_out_last got=%b want=0", b_out_last); end
        if (b_ram_addr !== '0)    begin failures++; $display("FAIL reset_ram_addr got=%0h want=0", b_ram_addr); end
    endtask

    task automatic test_single_word;
        fill(1'b0);
        write_word(16'd5, 64'hAA);
        run_burst(16'd5, 16'd0, 0, 99, 1'b1);
        checks += 5;
        if (first_valid != 3) begin failures++; $display("FAIL single_latency got=%0d want=3", first_valid); end
        if (got_data[0] !== 64'hAA) begin failures++; $display("FAIL single_data got=%0h want=aa", got_data[0]); end
        if (got_last[0] !== 1'b1) begin failures++; $display("FAIL single_last got=%b want=1", got_last[0]); end
        if (valid_cycles != 1) begin failures++; $display("FAIL single_valid_cycles got=%0d want=1", valid_cycles); end
        if (idle_cyc < 4) begin failures++; $display("FAIL single_idle_cycle got=%0d want>=4", idle_cyc); end
    endtask

    task automatic test_burst_full_rate;
        fill(1'b0);
        run_burst(16'd10, 16'd7, 0, 99, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data[i] !== DW'(10 + i) || got_last[i] !== (i == 7)) begin
                failures++;
                $display("FAIL full_rate_beat%0d got=%0h/%b want=%0h/%b", i, got_data[i], got_last[i], 10 + i, i == 7);
            end
        end
        checks += 3;
        if (first_valid != 3) begin failures++; $display("FAIL full_rate_latency got=%0d want=3", first_valid); end
        if (last_beat_cyc - first_valid != 7) begin
            failures++; $display("FAIL full_rate_span got=%0d want=7", last_beat_cyc - first_valid);
        end
        if (valid_cycles != 8) begin failures++; $display("FAIL full_rate_valid_cycles got=%0d want=8", valid_cycles); end
    endtask

    task automatic test_backpressure;
        run_burst(16'd10, 16'd7, 1, 99, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_data[i] !== DW'(10 + i) || got_last[i] !== (i == 7)) begin
                failures++;
                $display("FAIL backpressure_beat%0d got=%0h/%b want=%0h/%b", i, got_data[i], got_last[i], 10 + i, i == 7);
            end
        end
        checks++;
        if (stable_err != 0) begin failures++; $display("FAIL backpressure_stable got=%0d want=0", stable_err); end
    endtask

    task automatic test_wrap;
        logic [SDW-1:0] wrap_exp [4];
        wrap_exp = '{8'd14, 8'd15, 8'd0, 8'd1};
        use_small = 1'b1;
        run_burst(16'd14, 16'd3, 0, 99, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_data[i] !== DW'(wrap_exp[i]) || got_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL wrap_beat%0d got=%0h/%b want=%0h/%b", i, got_data[i], got_last[i], wrap_exp[i], i == 3);
            end
        end
        fill(1'b1);
        run_burst(16'd9, 16'd15, 2, 99, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_data[i] !== exp_word(16'd9, i) || got_last[i] !== (i == 15)) begin
                failures++;
                $display("FAIL whole_ram_beat%0d got=%0h/%b want=%0h/%b", i, got_data[i], got_last[i], exp_word(16'd9, i), i == 15);
            end
        end
        use_small = 1'b0;
    endtask

    task automatic test_coherency;
        fill(1'b0);
        wr_sched.push_back('{cyc: 1, addr: 16'd3, data: 64'h55});
        wr_sched.push_back('{cyc: 2, addr: 16'd3, data: 64'h66});
        run_burst(16'd3, 16'd0, 0, 99, 1'b1);
        wr_sched.delete();
        checks++;
        if (got_data[0] !== 64'h55) begin failures++; $display("FAIL coherency_same_cycle got=%0h want=55", got_data[0]); end
        run_burst(16'd3, 16'd0, 0, 99, 1'b1);
        checks++;
        if (got_data[0] !== 64'h66) begin failures++; $display("FAIL coherency_later_write got=%0h want=66", got_data[0]); end
    endtask

    task automatic test_reset_mid_burst;
        fill(1'b0);
        run_burst(16'd10, 16'd7, 0, 3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (b_out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b want=0", b_out_valid); end
        if (b_cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_cmd_ready got=%b want=1", b_cmd_ready); end
        if (b_busy !== 1'b0)      begin failures++; $display("FAIL abort_busy got=%b want=0", b_busy); end
        if (b_out_last !== 1'b0)  begin failures++; $display("FAIL abort_out_last got=%b want=0", b_out_last); end
        rst = 1'b0;
        run_burst(16'd0, 16'd1, 0, 99, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_data[i] !== DW'(i) || got_last[i] !== (i == 1)) begin
                failures++;
                $display("FAIL after_abort_beat%0d got=%0h/%b want=%0h/%b", i, got_data[i], got_last[i], i, i == 1);
            end
        end
        checks++;
        if (valid_cycles != 2) begin failures++; $display("FAIL after_abort_valid_cycles got=%0d want=2", valid_cycles); end
    endtask

    task automatic test_random_bursts;
        logic [AW-1:0] a, l;
        fill(1'b1);
        for (int k = 0; k < 6; k++) begin
            a = (k % 2 == 1) ? AW'($urandom()) : AW'(16'hFFF0 + $urandom_range(0, 15));
            l = AW'($urandom_range(0, 24));
            run_burst(a, l, 2, 99, 1'b1);
            for (int i = 0; i <= int'(l); i++) begin
                checks++;
                if (got_data[i] !== exp_word(a, i) || got_last[i] !== (i == int'(l))) begin
                    failures++;
                    $display("FAIL random%0d_beat%0d got=%0h/%b want=%0h/%b", k, i, got_data[i], got_last[i], exp_word(a, i), i == int'(l));
                end
            end
            checks++;
            if (stable_err != 0) begin failures++; $display("FAIL random%0d_stable got=%0d want=0", k, stable_err); end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single_word();
        test_burst_full_rate();
        test_backpressure();
        test_wrap();
        test_coherency();
        test_reset_mid_burst();
        test_random_bursts();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout reached time=%0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
